// File: rtl/rv32i_types.sv
// Shared types for the out-of-order core: default sizing constants and the
// reservation-station entry layout.
package rv32i_types;

  localparam int RS_DEPTH     = 8;
  localparam int RS_CDB_PORTS = 4;
  localparam int RS_PREG_W    = 6;
  localparam int RS_ROB_W     = 4;
  localparam int RS_PAYLOAD_W = 96;

  typedef struct packed {
    logic [RS_PREG_W-1:0]    ps1_idx;
    logic [RS_PREG_W-1:0]    ps2_idx;
    logic                    ps1_rdy;
    logic                    ps2_rdy;
    logic [RS_PREG_W-1:0]    pd_idx;
    logic [RS_ROB_W-1:0]     rob_idx;
    logic [RS_PAYLOAD_W-1:0] payload;
  } rs_entry_t;

endpackage

// File: rtl/reservation_station_n_age_select.sv
// Age matrix for the reservation station: tracks relative allocation order
// of entries and grants the oldest eligible one (one-hot).
module rs_age_select
  import rv32i_types::*;
#(
  parameter int DEPTH = RS_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_en,
  input  logic [DEPTH-1:0] alloc_oh,
  input  logic [DEPTH-1:0] elig,
  output logic [DEPTH-1:0] grant
);

  // older_q[j][i] set means entry j was allocated before entry i.
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];

  always_comb begin
    // NOTE: every variable gets a full default before any conditional update,
    // otherwise synthesis infers latches for the untouched paths.
    older_d = older_q;
    if (alloc_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_oh[i]) begin
          older_d[i] = '0;
          for (int j = 0; j < DEPTH; j++) begin
            if (j != i) older_d[j][i] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = elig[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (elig[j] && older_q[j][i]) grant[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else begin
      older_q <= older_d;
    end
  end

endmodule

// File: rtl/reservation_station_n.sv
// Reservation station: holds dispatched instructions until both sources are
// woken by the CDB, then issues the oldest ready entry to the functional unit.
module reservation_station_n
  import rv32i_types::*;
#(
  parameter int DEPTH     = RS_DEPTH,
  parameter int CDB_PORTS = RS_CDB_PORTS,
  parameter int PREG_W    = RS_PREG_W,
  parameter int ROB_W     = RS_ROB_W,
  parameter int PAYLOAD_W = RS_PAYLOAD_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        alloc_valid,
  output logic                        alloc_ready,
  input  logic [PREG_W-1:0]           alloc_ps1_idx,
  input  logic [PREG_W-1:0]           alloc_ps2_idx,
  input  logic                        alloc_ps1_rdy,
  input  logic                        alloc_ps2_rdy,
  input  logic [PREG_W-1:0]           alloc_pd_idx,
  input  logic [ROB_W-1:0]            alloc_rob_idx,
  input  logic [PAYLOAD_W-1:0]        alloc_payload,
  input  logic [CDB_PORTS-1:0]        cdb_valid,
  input  logic [CDB_PORTS*PREG_W-1:0] cdb_tag,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [PREG_W-1:0]           issue_ps1_idx,
  output logic [PREG_W-1:0]           issue_ps2_idx,
  output logic [PREG_W-1:0]           issue_pd_idx,
  output logic [ROB_W-1:0]            issue_rob_idx,
  output logic [PAYLOAD_W-1:0]        issue_payload,
  output logic [$clog2(DEPTH):0]      occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  rs_entry_t        entry_q [DEPTH];
  rs_entry_t        entry_d [DEPTH];
  rs_entry_t        new_entry;
  logic [DEPTH-1:0] elig, grant, alloc_oh;
  logic [IDX_W-1:0] sel_idx;
  logic [CNT_W-1:0] occ;
  logic             alloc_fire, issue_fire;

  // Tag 0 is the hardwired-ready register and never appears as a wakeup.
  function automatic logic cdb_hit(input logic [PREG_W-1:0]           tag,
                                   input logic [CDB_PORTS-1:0]        v,
                                   input logic [CDB_PORTS*PREG_W-1:0] t);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < CDB_PORTS; p++) begin
      if (v[p] && (t[p*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    end
    return hit && (tag != '0);
  endfunction

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) occ = occ + CNT_W'(valid_q[i]);
  end

  always_comb begin
    alloc_oh = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        alloc_oh    = '0;
        alloc_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = valid_q[i] && entry_q[i].ps1_rdy && entry_q[i].ps2_rdy;
    end
  end

  rs_age_select #(.DEPTH(DEPTH)) u_age_select (
    .clk      (clk),
    .rst      (rst),
    .alloc_en (alloc_fire),
    .alloc_oh (alloc_oh),
    .elig     (elig),
    .grant    (grant)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) sel_idx = IDX_W'(i);
    end
  end

  assign alloc_ready   = ~&valid_q;
  assign occupancy     = occ;
  assign issue_valid   = |elig;
  assign issue_ps1_idx = entry_q[sel_idx].ps1_idx;
  assign issue_ps2_idx = entry_q[sel_idx].ps2_idx;
  assign issue_pd_idx  = entry_q[sel_idx].pd_idx;
  assign issue_rob_idx = entry_q[sel_idx].rob_idx;
  assign issue_payload = entry_q[sel_idx].payload;

  assign alloc_fire = alloc_valid && alloc_ready && !flush;
  assign issue_fire = issue_valid && issue_ready && !flush;

  always_comb begin
    new_entry         = '0;
    new_entry.ps1_idx = alloc_ps1_idx;
    new_entry.ps2_idx = alloc_ps2_idx;
    new_entry.ps1_rdy = alloc_ps1_rdy || (alloc_ps1_idx == '0) ||
                        cdb_hit(alloc_ps1_idx, cdb_valid, cdb_tag);
    new_entry.ps2_rdy = alloc_ps2_rdy || (alloc_ps2_idx == '0) ||
                        cdb_hit(alloc_ps2_idx, cdb_valid, cdb_tag);
    new_entry.pd_idx  = alloc_pd_idx;
    new_entry.rob_idx = alloc_rob_idx;
    new_entry.payload = alloc_payload;
  end

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_hit(entry_q[i].ps1_idx, cdb_valid, cdb_tag)) entry_d[i].ps1_rdy = 1'b1;
      if (cdb_hit(entry_q[i].ps2_idx, cdb_valid, cdb_tag)) entry_d[i].ps2_rdy = 1'b1;
    end
    if (issue_fire) valid_d[sel_idx] = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_fire && alloc_oh[i]) begin
        valid_d[i] = 1'b1;
        entry_d[i] = new_entry;
      end
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      // NOTE: the entry array is reset in full, not just the valid bits, so the
      // ready bits start cleared; the array is small enough for plain flops.
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

endmodule
